// File: rtl/sca_rd_seq.sv
// SCA readout sequencer: drains the trigger-block FIFO one entry at a time and
// issues one ADC conversion per SCA sample, releasing each block as it finishes.
module sca_rd_seq #(
    parameter int NSAMP    = 8,
    parameter int CONV_CYC = 4,
    parameter int TMR      = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENBL50,
    input  logic       TEMPTY,
    input  logic       SCND_BLK,
    input  logic [3:0] BLKOUT,
    input  logic [7:0] L1POUT,
    input  logic       OUT_BUSY,
    output logic       TRGDONE,
    output logic       ADC_CONV,
    output logic [3:0] RD_BLK,
    output logic [2:0] RD_SMP,
    output logic       L1A_FLAG,
    output logic       BLK_FREE,
    output logic [3:0] BLK_FREE_ADDR,
    output logic       RD_ACTIVE,
    output logic [7:0] EVT_CNT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CONV   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_BLKEND = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [2:0] LAST_SMP  = 3'(NSAMP - 1);
    localparam logic [3:0] WAIT_INIT = 4'(CONV_CYC - 1);

    // All sequencer state lives in one vector so it can be stored once or triplicated.
    typedef struct packed {
        logic [2:0] state;
        logic [3:0] rd_blk;
        logic [2:0] rd_smp;
        logic [7:0] mask;
        logic       pend;
        logic       fbd;
        logic [3:0] wcnt;
        logic       adc_conv;
        logic       l1a;
        logic [7:0] evt_cnt;
    } seq_t;

    function automatic seq_t vote3(input seq_t a, input seq_t b, input seq_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    seq_t cur_s;
    seq_t nxt_s;

    // Next-state computation for the readout sequence.
    always_comb begin
        nxt_s          = cur_s;
        nxt_s.adc_conv = 1'b0;
        nxt_s.l1a      = 1'b0;
        case (cur_s.state)
            S_IDLE: begin
                if (!TEMPTY) begin
                    nxt_s.state = S_LOAD;
                end else begin
                    nxt_s.state = S_IDLE;
                end
            end
            S_LOAD: begin
                nxt_s.rd_blk = BLKOUT;
                nxt_s.mask   = L1POUT;
                nxt_s.pend   = SCND_BLK;
                nxt_s.fbd    = 1'b0;
                nxt_s.rd_smp = 3'd0;
                nxt_s.state  = S_CONV;
            end
            S_CONV: begin
                if (ENBL50 && !OUT_BUSY) begin
                    nxt_s.adc_conv = 1'b1;
                    nxt_s.l1a      = cur_s.mask[cur_s.rd_smp] & ~cur_s.fbd;
                    nxt_s.wcnt     = WAIT_INIT;
                    nxt_s.state    = S_WAIT;
                end else begin
                    nxt_s.state = S_CONV;
                end
            end
            S_WAIT: begin
                if (cur_s.wcnt == 4'd0) begin
                    if (cur_s.rd_smp == LAST_SMP) begin
                        nxt_s.state = S_BLKEND;
                    end else begin
                        nxt_s.rd_smp = cur_s.rd_smp + 3'd1;
                        nxt_s.state  = S_CONV;
                    end
                end else begin
                    nxt_s.wcnt = cur_s.wcnt - 4'd1;
                end
            end
            S_BLKEND: begin
                // Second block of a two-block entry wraps 15 -> 0.
                if (cur_s.pend && !cur_s.fbd) begin
                    nxt_s.fbd    = 1'b1;
                    nxt_s.rd_blk = cur_s.rd_blk + 4'd1;
                    nxt_s.rd_smp = 3'd0;
                    nxt_s.state  = S_CONV;
                end else begin
                    nxt_s.state = S_DONE;
                end
            end
            S_DONE: begin
                nxt_s.evt_cnt = cur_s.evt_cnt + 8'd1;
                nxt_s.state   = S_IDLE;
            end
            default: begin
                nxt_s.state = S_IDLE;
            end
        endcase
    end

    if (TMR != 0) begin : g_tmr
        seq_t seq_a_r;
        seq_t seq_b_r;
        seq_t seq_c_r;

        // Three copies of the state, majority-voted on read.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                seq_a_r <= '0;
                seq_b_r <= '0;
                seq_c_r <= '0;
            end else begin
                seq_a_r <= nxt_s;
                seq_b_r <= nxt_s;
                seq_c_r <= nxt_s;
            end
        end

        assign cur_s = vote3(seq_a_r, seq_b_r, seq_c_r);
    end else begin : g_single
        seq_t seq_r;

        // Single copy of the sequencer state.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                seq_r <= '0;
            end else begin
                seq_r <= nxt_s;
            end
        end

        assign cur_s = seq_r;
    end

    assign TRGDONE       = (cur_s.state == S_DONE);
    assign BLK_FREE      = (cur_s.state == S_BLKEND);
    assign BLK_FREE_ADDR = (cur_s.state == S_BLKEND) ? cur_s.rd_blk : 4'd0;
    assign RD_ACTIVE     = (cur_s.state != S_IDLE);
    assign ADC_CONV      = cur_s.adc_conv;
    assign L1A_FLAG      = cur_s.l1a;
    assign RD_BLK        = cur_s.rd_blk;
    assign RD_SMP        = cur_s.rd_smp;
    assign EVT_CNT       = cur_s.evt_cnt;

endmodule

// File: tb/tb_sca_rd_seq.sv
// Scoreboard bench for sca_rd_seq: a FIFO model feeds entries, a reference model
// predicts strobes/releases/pops, and a monitor compares them as they appear.
module tb_sca_rd_seq;

    localparam int NSAMP      = 8;
    localparam int CONV_CYC   = 4;
    localparam int PER        = CONV_CYC + 1;
    localparam int BLK_SPAN   = NSAMP * PER + 1;
    localparam int ENTRY_SPAN = NSAMP * PER + 4;

    logic       CLK;
    logic       RST;
    logic       ENBL50;
    logic       TEMPTY;
    logic       SCND_BLK;
    logic [3:0] BLKOUT;
    logic [7:0] L1POUT;
    logic       OUT_BUSY;
    logic       TRGDONE;
    logic       ADC_CONV;
    logic [3:0] RD_BLK;
    logic [2:0] RD_SMP;
    logic       L1A_FLAG;
    logic       BLK_FREE;
    logic [3:0] BLK_FREE_ADDR;
    logic       RD_ACTIVE;
    logic [7:0] EVT_CNT;

    sca_rd_seq #(.NSAMP(NSAMP), .CONV_CYC(CONV_CYC), .TMR(0)) dut (
        .CLK(CLK), .RST(RST), .ENBL50(ENBL50), .TEMPTY(TEMPTY), .SCND_BLK(SCND_BLK),
        .BLKOUT(BLKOUT), .L1POUT(L1POUT), .OUT_BUSY(OUT_BUSY), .TRGDONE(TRGDONE),
        .ADC_CONV(ADC_CONV), .RD_BLK(RD_BLK), .RD_SMP(RD_SMP), .L1A_FLAG(L1A_FLAG),
        .BLK_FREE(BLK_FREE), .BLK_FREE_ADDR(BLK_FREE_ADDR), .RD_ACTIVE(RD_ACTIVE),
        .EVT_CNT(EVT_CNT)
    );

    // kind: 0 = conversion, 1 = block release, 2 = FIFO pop
    typedef struct {
        int kind;
        int blk;
        int smp;
        int flag;
        int cyc;
    } ev_t;

    typedef struct {
        int blk;
        int l1p;
        int scnd;
    } ent_t;

    ev_t  exp_q[$];
    ent_t fifo_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   model_cnt = 0;
    bit   pop_req   = 1'b0;
    bit   prev_ok   = 1'b0;
    bit   last_done = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Reference model: an entry yields NSAMP conversions per block, a release per
    // block, then one pop. Cycle numbers follow the ideal-latency rules (t0 < 0 = unknown).
    task automatic add_expect(input ent_t e, input int t0, input int shift_k, input int shift);
        ev_t ev;
        int  nb;
        int  tail;
        nb   = (e.scnd != 0) ? 2 : 1;
        tail = (shift_k >= 0) ? shift : 0;
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < NSAMP; s++) begin
                ev.kind = 0;
                ev.blk  = (e.blk + b) % 16;
                ev.smp  = s;
                ev.flag = (b == 0) ? ((e.l1p >> s) & 1) : 0;
                ev.cyc  = (t0 < 0) ? -1 : t0 + 3 + b * BLK_SPAN + s * PER +
                          ((shift_k >= 0 && b * NSAMP + s >= shift_k) ? shift : 0);
                exp_q.push_back(ev);
            end
            ev.kind = 1;
            ev.blk  = (e.blk + b) % 16;
            ev.smp  = 0;
            ev.flag = 0;
            ev.cyc  = (t0 < 0) ? -1 : t0 + 2 + NSAMP * PER + b * BLK_SPAN + tail;
            exp_q.push_back(ev);
        end
        ev.kind = 2;
        ev.blk  = 0;
        ev.smp  = 0;
        ev.flag = 0;
        ev.cyc  = (t0 < 0) ? -1 : t0 + 3 + NSAMP * PER + (nb - 1) * BLK_SPAN + tail;
        exp_q.push_back(ev);
    endtask

    task automatic push_entry(input int blk, input int l1p, input int scnd,
                              input int t0, input int shift_k, input int shift);
        ent_t e;
        e.blk  = blk;
        e.l1p  = l1p;
        e.scnd = scnd;
        fifo_q.push_back(e);
        add_expect(e, t0, shift_k, shift);
    endtask

    task automatic chk_outs_zero(input string name);
        chk(name, {TRGDONE, ADC_CONV, RD_BLK, RD_SMP, L1A_FLAG, BLK_FREE,
                   BLK_FREE_ADDR, RD_ACTIVE, EVT_CNT}, 64'd0);
    endtask

    task automatic take_event(input int kind, input int blk, input int smp, input int flag);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d blk %0d smp %0d expected none (cycle %0d)",
                     kind, blk, smp, cyc);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("event_k%0d_b%0d_s%0d", e.kind, e.blk, e.smp),
                (kind << 16) | (blk << 8) | (smp << 4) | flag,
                (e.kind << 16) | (e.blk << 8) | (e.smp << 4) | e.flag);
            if (e.cyc >= 0) begin
                chk($sformatf("event_cycle_k%0d_s%0d", e.kind, e.smp), cyc, e.cyc);
            end
        end
    endtask

    // FIFO model: first-word-fall-through, popped after each TRGDONE.
    initial forever begin
        @(posedge CLK);
        #2;
        if (pop_req) begin
            pop_req = 1'b0;
            if (fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
            end
        end
        if (fifo_q.size() > 0) begin
            TEMPTY   = 1'b0;
            BLKOUT   = 4'(fifo_q[0].blk);
            L1POUT   = 8'(fifo_q[0].l1p);
            SCND_BLK = (fifo_q[0].scnd != 0);
        end else begin
            TEMPTY = 1'b1;
        end
    end

    // Monitor: compares every DUT output event against the scoreboard.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            prev_ok   = 1'b0;
            last_done = 1'b0;
        end else begin
            if (last_done) begin
                chk("post_done_evt_cnt", EVT_CNT, model_cnt);
                chk("post_done_idle", RD_ACTIVE, 0);
                last_done = 1'b0;
            end
            if (ADC_CONV) begin
                chk("conv_after_enable", prev_ok, 1);
                take_event(0, RD_BLK, RD_SMP, L1A_FLAG);
            end
            if (BLK_FREE) begin
                take_event(1, BLK_FREE_ADDR, 0, 0);
            end
            if (TRGDONE) begin
                chk("trgdone_not_empty", TEMPTY, 0);
                chk("trgdone_evt_cnt", EVT_CNT, model_cnt);
                model_cnt = (model_cnt + 1) % 256;
                take_event(2, 0, 0, 0);
                pop_req   = 1'b1;
                last_done = 1'b1;
            end
            prev_ok = ENBL50 & ~OUT_BUSY;
        end
    end

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) begin
                idle = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d events pending expected 0 (cycle %0d)", exp_q.size(), cyc);
            finish_run();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int t0;
        int issued;
        RST      = 1'b1;
        ENBL50   = 1'b1;
        OUT_BUSY = 1'b0;
        TEMPTY   = 1'b1;
        SCND_BLK = 1'b0;
        BLKOUT   = 4'd0;
        L1POUT   = 8'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk_outs_zero("reset_state");
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        push_entry(5, 8'h18, 0, cyc, -1, 0);
        wait_idle(200);
        push_entry(15, 8'hFF, 1, cyc, -1, 0);
        wait_idle(300);

        t0 = cyc;
        push_entry(9, 8'h24, 0, t0, 2, 10);
        repeat (12) @(posedge CLK);
        #1;
        OUT_BUSY = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        OUT_BUSY = 1'b0;
        wait_idle(300);

        t0 = cyc;
        push_entry(1, 8'h01, 0, t0, -1, 0);
        push_entry(2, 8'h80, 0, t0 + ENTRY_SPAN, -1, 0);
        push_entry(3, 8'h55, 0, t0 + 2 * ENTRY_SPAN, -1, 0);
        wait_idle(400);

        push_entry(7, 8'hA5, 1, -1, -1, 0);
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            ENBL50 = ~ENBL50;
            @(posedge CLK);
            #1;
        end
        ENBL50 = 1'b1;
        wait_idle(10);

        t0 = cyc;
        push_entry(4, 8'hFF, 0, t0, -1, 0);
        repeat (19) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk_outs_zero("reset_midop");
        exp_q.delete();
        pop_req   = 1'b0;
        model_cnt = 0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("fifo_retained", fifo_q.size(), 1);
        if (fifo_q.size() > 0) begin
            add_expect(fifo_q[0], cyc, -1, 0);
        end
        wait_idle(300);

        issued = 0;
        for (int i = 0; i < 40000 && issued < 270; i++) begin
            if (fifo_q.size() < 3 && $urandom_range(3) == 0) begin
                push_entry($urandom_range(15), $urandom_range(255),
                           ($urandom_range(3) == 0) ? 1 : 0, -1, -1, 0);
                issued++;
            end
            ENBL50   = ($urandom_range(3) != 0);
            OUT_BUSY = ($urandom_range(7) == 0);
            @(posedge CLK);
            #1;
        end
        chk("random_issued", issued, 270);
        ENBL50   = 1'b1;
        OUT_BUSY = 1'b0;
        wait_idle(2000);

        chk("final_events_drained", exp_q.size(), 0);
        chk("final_evt_cnt", EVT_CNT, model_cnt);
        finish_run();
    end

endmodule

// File: doc/sca_rd_seq.md
Name: sca_rd_seq

Overview:
- Readout sequencer that drains the trigger-block FIFO (empty flag, block address, second-block flag, L1A-position mask) one entry at a time.
- For each entry it steps through NSAMP SCA samples of the stored block, plus the following block when the second-block flag is set, issuing one ADC conversion strobe per sample.
- It releases each SCA block back to the allocator as that block finishes, then pops the FIFO with a one-cycle TRGDONE.
- It sits between the readout-control FIFO and the ADC/SCA-address datapath.

Parameters:
- NSAMP, 8, samples per SCA block; legal range 1..8; sample index is 3 bits.
- CONV_CYC, 4, wait cycles after each ADC_CONV before the next sample is eligible; legal range 1..15.
- TMR, 0, triplicate state and counters when 1; no functional change.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- ENBL50  in  1  conversion-phase enable; a conversion is issued only in a cycle where this is high
- TEMPTY  in  1  FIFO empty; entry outputs are valid while low (first-word-fall-through)
- SCND_BLK  in  1  entry spans two consecutive blocks
- BLKOUT  in  4  first SCA block of the entry
- L1POUT  in  8  L1A position mask; bit i marks sample i of the first block
- OUT_BUSY  in  1  downstream backpressure; holds before the next conversion
- TRGDONE  out  1  one-cycle FIFO pop
- ADC_CONV  out  1  one-cycle conversion strobe, registered
- RD_BLK  out  4  SCA block being read
- RD_SMP  out  3  sample index being read
- L1A_FLAG  out  1  registered; valid with ADC_CONV
- BLK_FREE  out  1  one-cycle block release
- BLK_FREE_ADDR  out  4  released block address
- RD_ACTIVE  out  1  high whenever the state is not IDLE
- EVT_CNT  out  8  count of completed entries; wraps 255->0

Behaviour:
- Reset (async): state IDLE. All outputs 0. Latched block, mask, second-block flag, sample counter and wait counter cleared.
- States: IDLE, LOAD, CONV, WAIT, BLKEND, DONE.
- IDLE: if TEMPTY=0 go to LOAD, else stay.
- LOAD: latch BLKOUT into RD_BLK, L1POUT into the mask reg, SCND_BLK into the pending flag. Clear first-block-done, RD_SMP=0. Go to CONV.
- CONV:
  - If ENBL50=1 and OUT_BUSY=0: next cycle ADC_CONV=1 and L1A_FLAG=mask[RD_SMP] & first-block-not-done; wcnt=CONV_CYC-1; go to WAIT.
  - Otherwise stay in CONV with no strobe. OUT_BUSY held indefinitely stalls here.
- WAIT: if wcnt=0 then go to BLKEND when RD_SMP=NSAMP-1, else RD_SMP+1 and go to CONV. Otherwise wcnt-1. OUT_BUSY is ignored during WAIT.
- BLKEND:
  - BLK_FREE=1 and BLK_FREE_ADDR=RD_BLK for this cycle (combinational decode of registered state/address).
  - If pending=1 and first-block-done=0: set first-block-done, RD_BLK=RD_BLK+1 mod 16 (15->0), RD_SMP=0, go to CONV.
  - Else go to DONE.
- DONE: TRGDONE=1 for exactly this cycle; EVT_CNT+1; go to IDLE.
- IDLE re-evaluates TEMPTY the cycle after DONE, so back-to-back entries have no extra gap and no double pop.
- Latency, with ENBL50=1 and OUT_BUSY=0, where t is the first IDLE cycle with TEMPTY=0:
  - LOAD t+1, CONV t+2, first ADC_CONV t+3.
  - Conversions are spaced CONV_CYC+1 cycles apart.
  - One block: BLKEND at t+2+(NSAMP-1)(CONV_CYC+1)+CONV_CYC+1; TRGDONE one cycle later.
- L1A_FLAG is always 0 for the second block.
- ENBL50 low only delays the CONV exit; sample count and spacing are otherwise unaffected.
- TEMPTY and the entry inputs are ignored after LOAD. TRGDONE is never asserted while TEMPTY=1.
- Reset mid-operation: immediate IDLE with no TRGDONE or BLK_FREE; the FIFO entry is retained by the FIFO.
- EVT_CNT wraps 255->0 with no flag.

Test Plan:
- Single block, defaults, TEMPTY falls at t, BLKOUT=5, L1POUT=0x18 -> 8 ADC_CONV at t+3,+8,...,+38; L1A_FLAG on the 4th and 5th strobes (t+18, t+23); BLK_FREE with addr 5 at t+42; TRGDONE at t+43 only; EVT_CNT=1.
- Two blocks, BLKOUT=15, SCND_BLK=1 -> BLK_FREE addr 15 at t+42; RD_BLK=0 from t+43; 8 more strobes t+44..t+79, none with L1A_FLAG; BLK_FREE addr 0 at t+83; TRGDONE at t+84.
- OUT_BUSY high for 10 cycles while in CONV before the 3rd sample -> that strobe and all later strobes/TRGDONE shift by exactly 10 cycles; no strobe during the stall; total 8 strobes.
- ENBL50 toggling 1/0 each cycle -> strobes occur only in cycles where ENBL50 was high the prior cycle; count remains 8; exactly one TRGDONE per entry.
- Three queued entries (TEMPTY low until the 3rd pop) -> three TRGDONEs; LOAD one cycle after each IDLE; EVT_CNT=3; EVT_CNT preloaded to 255 then one entry -> 0.
- RST asserted during the 4th WAIT -> all outputs 0 asynchronously; no TRGDONE or BLK_FREE; after release with TEMPTY low, a fresh entry restarts at RD_SMP=0.
